if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 111 +++++++++++
 tb/tb_if_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one-outstanding memory fetch feeding a 2-entry {pc,inst} queue to decode.
// Grant-to-decode latency is 2 cycles. Credits (queue count + outstanding) gate requests, and redirects flush the queue.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        out_q, out_d;
  logic        disc_q, disc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];

  logic [1:0]  credit_used;
  logic        grant;
  logic        rsp;
  logic        push;
  logic        pop;

  assign credit_used = cnt_q + {1'b0, out_q};

  // Outputs are gated by reset so nothing is offered while rst is low.
  assign imem_req_o  = rst & ~out_q & (credit_used < 2'd2) & ~redirect_i;
  assign imem_addr_o = pc_q;
  assign id_valid_o  = rst & (cnt_q != 2'd0) & ~redirect_i;
  assign id_inst_o   = fifo_inst_q[rd_ptr_q];
  assign id_pc_o     = fifo_pc_q[rd_ptr_q];

  assign grant = imem_req_o & imem_gnt_i;
  assign rsp   = imem_rvalid_i & out_q;
  assign push  = rsp & ~disc_q & ~redirect_i;
  assign pop   = id_valid_o & id_ready_i;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    disc_d   = disc_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_i) begin
      pc_d     = {redirect_pc_i[31:2], 2'b00};
      cnt_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      // A response arriving this cycle is simply dropped; only a still-pending one must be discarded later.
      out_d    = out_q & ~imem_rvalid_i;
      disc_d   = out_q & ~imem_rvalid_i;
    end else begin
      if (grant) begin
        pc_d     = pc_q + 32'd4;
        rsp_pc_d = pc_q;
        out_d    = 1'b1;
      end
      if (rsp) begin
        out_d  = 1'b0;
        disc_d = 1'b0;
      end
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= 1'b0;
      disc_q   <= 1'b0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model with programmable response delay, scoreboard of expected {pc,inst}.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] glog[$];
  int          pop_cyc[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pops = 0;
  int          rel = 0;
  int          rv_delay = 1;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_inst_o     (id_inst_o),
    .id_pc_o       (id_pc_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    ent_t e;
    e.pc   = a;
    e.inst = inst_of(a);
    exp_q.push_back(e);
  endtask

  // Samples the current cycle, advances to the next negedge and drives the memory response.
  task automatic step();
    ent_t        e;
    bit          g;
    logic [31:0] ga;
    #1;
    if (id_valid_o && id_ready_i) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_pop observed pc=%08h expected=no_pop", id_pc_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc_o, e.pc);
        chk("id_inst", id_inst_o, e.inst);
      end
      pop_cyc.push_back(cyc);
      pops++;
    end
    g  = imem_req_o && imem_gnt_i;
    ga = imem_addr_o;
    if (g) glog.push_back(ga);
    @(negedge clk);
    cyc++;
    imem_rvalid_i = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_cnt  = rv_delay;
      pend_addr = ga;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_of(pend_addr);
        pend          = 1'b0;
      end
    end
  endtask

  task automatic run_pops(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && pops < target; i++) step();
    chk(tag, 32'(pops), 32'(target));
  endtask

  task automatic do_reset(input int dly, input logic rdy);
    rst           = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    id_ready_i    = 1'b0;
    rv_delay      = dly;
    pend          = 1'b0;
    exp_q.delete();
    glog.delete();
    pop_cyc.delete();
    pops = 0;
    step();
    step();
    #1;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    rst        = 1'b1;
    imem_gnt_i = 1'b1;
    id_ready_i = rdy;
    rel        = cyc;
    #1;
    chk("rel_req", 32'(imem_req_o), 32'd1);
    chk("rel_addr", imem_addr_o, 32'h0000_0000);
  endtask

  initial begin
    // Streaming fetch with immediate grant and 1-cycle response.
    do_reset(1, 1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    run_pops(3, 40, "stream_pops");
    id_ready_i = 1'b0;
    chk("stream_latency", 32'(pop_cyc[0] - rel), 32'd2);
    chk("stream_rate01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
    chk("stream_rate12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);

    // Decode stall: queue fills to two entries and requests halt.
    do_reset(1, 1'b0);
    push_exp(32'h0);
    push_exp(32'h4);
    repeat (10) step();
    #1;
    chk("stall_req", 32'(imem_req_o), 32'd0);
    chk("stall_valid", 32'(id_valid_o), 32'd1);
    chk("stall_head", id_pc_o, 32'h0);
    id_ready_i = 1'b1;
    run_pops(2, 20, "stall_pops");
    id_ready_i = 1'b0;
    repeat (4) step();
    #1;
    chk("stall_next_valid", 32'(id_valid_o), 32'd1);
    chk("stall_next_pc", id_pc_o, 32'h8);
    chk("stall_next_inst", id_inst_o, inst_of(32'h8));

    // Redirect while the request for 0x8 is still outstanding.
    do_reset(3, 1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    for (int i = 0; i < 40 && glog.size() < 3; i++) step();
    chk("redir_grants", 32'(glog.size()), 32'd3);
    chk("redir_pend_addr", glog[2], 32'h8);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    #1;
    chk("redir_req", 32'(imem_req_o), 32'd0);
    chk("redir_valid", 32'(id_valid_o), 32'd0);
    push_exp(32'h100);
    push_exp(32'h104);
    step();
    redirect_i = 1'b0;
    run_pops(4, 60, "redir_pops");
    id_ready_i = 1'b0;
    chk("redir_target", glog[3], 32'h100);

    // Redirect coinciding with grant and decode-ready.
    do_reset(1, 1'b0);
    step();
    step();
    #1;
    chk("coin_pre_valid", 32'(id_valid_o), 32'd1);
    chk("coin_pre_req", 32'(imem_req_o), 32'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    id_ready_i    = 1'b1;
    #1;
    chk("coin_valid", 32'(id_valid_o), 32'd0);
    chk("coin_req", 32'(imem_req_o), 32'd0);
    push_exp(32'h200);
    push_exp(32'h204);
    step();
    redirect_i = 1'b0;
    run_pops(2, 30, "coin_pops");
    id_ready_i = 1'b0;
    chk("coin_target", glog[1], 32'h200);

    // Fetch PC wraps from the top of the address space; target low bits ignored.
    do_reset(1, 1'b1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    push_exp(32'h4);
    step();
    redirect_i = 1'b0;
    run_pops(3, 40, "wrap_pops");
    id_ready_i = 1'b0;
    chk("wrap_first", glog[0], 32'hFFFF_FFFC);
    chk("wrap_next", glog[1], 32'h0);

    // Reset mid-transaction; the stale response arrives after release.
    do_reset(3, 1'b0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    step();
    chk("mid_grant", glog[0], 32'h40);
    rst        = 1'b0;
    imem_gnt_i = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req_o), 32'd0);
    chk("mid_rst_valid", 32'(id_valid_o), 32'd0);
    step();
    rst = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    #1;
    chk("mid_rel_req", 32'(imem_req_o), 32'd1);
    chk("mid_rel_addr", imem_addr_o, 32'h0);
    step();
    chk("mid_stale_rvalid", 32'(imem_rvalid_i), 32'd1);
    step();
    imem_gnt_i = 1'b1;
    id_ready_i = 1'b1;
    run_pops(2, 40, "mid_pops");
    id_ready_i = 1'b0;
    step();
    chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
